// File: rtl/mileage_bcd_recorder.sv
// Mileage record counter with a serial double-dabble binary-to-BCD converter.
// A change to the record schedules one conversion; bcd updates atomically with a one-cycle strobe.
module mileage_bcd_recorder #(
  parameter int REC_W     = 27,
  parameter int DIGITS    = 7,
  parameter int MAX_COUNT = 9_999_999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  power_on,
  input  logic                  moving,
  input  logic                  dist_tick,
  input  logic                  clr,
  output logic [REC_W-1:0]      record,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(REC_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [REC_W-1:0]   rec_next;
  logic               rec_change;
  logic               pending;
  logic [REC_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   acc, acc_adj;
  logic [CNT_W-1:0]   bit_cnt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rec_next = record;
    if (clr)
      rec_next = '0;
    else if (dist_tick && power_on && moving)
      rec_next = (record == REC_W'(MAX_COUNT)) ? '0 : record + 1'b1;
    rec_change = (rec_next != record);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      record  <= '0;
      pending <= 1'b0;
    end else begin
      record <= rec_next;
      // A new change wins over the IDLE clear so no update is ever dropped.
      if (rec_change)
        pending <= 1'b1;
      else if (state == IDLE)
        pending <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pending) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Add-3 correction per digit before each shift; digits >= 5 become >= 8 so the shift carries.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++)
      if (acc[4*d +: 4] >= 4'd5)
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
  end

  // NOTE: datapath registers are reset as well; they are few and it keeps X out of bcd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= (state == DONE);
      unique case (state)
        LOAD: begin
          shift_reg <= record;
          acc       <= '0;
          bit_cnt   <= CNT_W'(REC_W);
        end
        SHIFT: begin
          {acc, shift_reg} <= {acc_adj, shift_reg} << 1;
          bit_cnt          <= bit_cnt - 1'b1;
        end
        DONE:    bcd <= acc;
        default: ;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == SHIFT);

endmodule
